// File: rtl/popcount_pkg.sv
// Shared helpers for the popcount accumulator: count-width function and
// overflow-policy selectors.
package popcount_pkg;

    localparam int SAT_WRAP  = 0;
    localparam int SAT_CLAMP = 1;

    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/csa_popcount.sv
// Combinational population count: repeated 3:2 full-adder column reduction
// down to two rows, then a final ripple add.
module csa_popcount
    import popcount_pkg::*;
#(
    parameter int N_IN = 12
) (
    input  logic [N_IN-1:0]          in_data,
    output logic [cnt_w(N_IN)-1:0]   count
);

    localparam int unsigned CW = cnt_w(N_IN);
    localparam int unsigned D  = N_IN + 2;
    localparam int unsigned IW = $clog2(D);

    logic [D-1:0]  col [CW];
    logic [D-1:0]  nxt [CW];
    int unsigned   h   [CW];
    int unsigned   nh  [CW];
    logic          fa_s;
    logic          fa_c;
    logic          rc;
    logic [IW-1:0] idx;

    // Column heights depend only on N_IN, so every loop folds to a fixed tree.
    always_comb begin
        fa_s  = 1'b0;
        fa_c  = 1'b0;
        rc    = 1'b0;
        idx   = '0;
        count = '0;
        for (int unsigned c = 0; c < CW; c++) begin
            col[c] = '0;
            nxt[c] = '0;
            h[c]   = 0;
            nh[c]  = 0;
        end
        col[0][N_IN-1:0] = in_data;
        h[0]             = N_IN;

        for (int unsigned r = 0; r < N_IN; r++) begin
            for (int unsigned c = 0; c < CW; c++) begin
                nxt[c] = '0;
                nh[c]  = 0;
            end
            for (int unsigned c = 0; c < CW; c++) begin
                for (int unsigned g = 0; g < D / 3; g++) begin
                    if (3 * g + 2 < h[c]) begin
                        fa_s = col[c][3*g] ^ col[c][3*g+1] ^ col[c][3*g+2];
                        fa_c = (col[c][3*g] & col[c][3*g+1]) |
                               (col[c][3*g] & col[c][3*g+2]) |
                               (col[c][3*g+1] & col[c][3*g+2]);
                        if (nh[c] < D) begin
                            idx         = IW'(nh[c]);
                            nxt[c][idx] = fa_s;
                            nh[c]       = nh[c] + 1;
                        end
                        // carries out of the top column are always zero
                        if (c + 1 < CW && nh[c+1] < D) begin
                            idx           = IW'(nh[c+1]);
                            nxt[c+1][idx] = fa_c;
                            nh[c+1]       = nh[c+1] + 1;
                        end
                    end
                end
                for (int unsigned k = 0; k < D; k++) begin
                    if (k >= 3 * (h[c] / 3) && k < h[c] && nh[c] < D) begin
                        idx         = IW'(nh[c]);
                        nxt[c][idx] = col[c][k];
                        nh[c]       = nh[c] + 1;
                    end
                end
            end
            for (int unsigned c = 0; c < CW; c++) begin
                col[c] = nxt[c];
                h[c]   = nh[c];
            end
        end

        for (int unsigned c = 0; c < CW; c++) begin
            count[c] = col[c][0] ^ col[c][1] ^ rc;
            rc       = (col[c][0] & col[c][1]) | (rc & (col[c][0] ^ col[c][1]));
        end
    end

endmodule

// File: rtl/popcount_acc_pipe.sv
// Two-stage popcount accumulator: per-beat count register, then frame
// accumulation into a valid/ready result register with global stall.
module popcount_acc_pipe
    import popcount_pkg::*;
#(
    parameter int N_IN  = 12,
    parameter int ACC_W = 16,
    parameter int SAT   = SAT_WRAP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N_IN-1:0]  in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_parity,
    output logic             out_overflow
);

    localparam int CW = cnt_w(N_IN);

    logic             en;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    s1_cnt;
    logic             s1_valid;
    logic             s1_last;
    logic [ACC_W-1:0] acc;
    logic             par;
    logic             ovf;
    logic [ACC_W:0]   t;
    logic [ACC_W-1:0] sum_n;
    logic             par_n;
    logic             ovf_n;

    assign en       = !(out_valid && !out_ready);
    assign in_ready = en && !rst;

    csa_popcount #(.N_IN(N_IN)) u_csa (
        .in_data (in_data),
        .count   (cnt)
    );

    always_comb begin
        t     = {1'b0, acc} + (ACC_W + 1)'(s1_cnt);
        ovf_n = ovf | t[ACC_W];
        par_n = par ^ s1_cnt[0];
        if (SAT == SAT_CLAMP && t[ACC_W]) begin
            sum_n = '1;
        end else begin
            sum_n = t[ACC_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_cnt   <= '0;
        end else if (en) begin
            s1_valid <= in_valid;
            s1_last  <= in_last;
            s1_cnt   <= cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc          <= '0;
            par          <= 1'b0;
            ovf          <= 1'b0;
            out_sum      <= '0;
            out_parity   <= 1'b0;
            out_overflow <= 1'b0;
        end else if (en && s1_valid) begin
            if (s1_last) begin
                out_sum      <= sum_n;
                out_parity   <= par_n;
                out_overflow <= ovf_n;
                acc          <= '0;
                par          <= 1'b0;
                ovf          <= 1'b0;
            end else begin
                acc <= sum_n;
                par <= par_n;
                ovf <= ovf_n;
            end
        end
    end

    // A fresh result loading on the same edge as a handshake keeps valid high.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
        end else if (en && s1_valid && s1_last) begin
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_popcount_acc_pipe.sv
// Directed bench: a wrapping and a saturating instance (ACC_W=8) share stimulus.
module tb_popcount_acc_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_last;
    logic        out_ready;
    logic [11:0] in_data;

    logic        rdy_w, rdy_s;
    logic        ov_w, ov_s;
    logic        par_w, par_s;
    logic        of_w, of_s;
    logic [7:0]  sum_w, sum_s;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [11:0] data;
        logic [7:0]  sum;
        logic        par;
    } vec_t;

    vec_t vecs [6];

    always #5 clk = ~clk;

    popcount_acc_pipe #(.N_IN(12), .ACC_W(8), .SAT(0)) dut_w (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (rdy_w),
        .in_data      (in_data),
        .in_last      (in_last),
        .out_valid    (ov_w),
        .out_ready    (out_ready),
        .out_sum      (sum_w),
        .out_parity   (par_w),
        .out_overflow (of_w)
    );

    popcount_acc_pipe #(.N_IN(12), .ACC_W(8), .SAT(1)) dut_s (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (rdy_s),
        .in_data      (in_data),
        .in_last      (in_last),
        .out_valid    (ov_s),
        .out_ready    (out_ready),
        .out_sum      (sum_s),
        .out_parity   (par_s),
        .out_overflow (of_s)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic [11:0] d, input logic l);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic expect_result(input string name, input logic [7:0] ew, input logic [7:0] es,
                                 input logic ep, input logic eow, input logic eos,
                                 output int waited);
        waited = 0;
        while (!ov_w && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check({name, "_valid_w"}, ov_w, 1);
        check({name, "_valid_s"}, ov_s, 1);
        check({name, "_sum_w"}, sum_w, ew);
        check({name, "_sum_s"}, sum_s, es);
        check({name, "_par_w"}, par_w, ep);
        check({name, "_par_s"}, par_s, ep);
        check({name, "_ovf_w"}, of_w, eow);
        check({name, "_ovf_s"}, of_s, eos);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        logic [11:0] v;

        vecs[0] = '{12'h000, 8'd0,  1'b0};
        vecs[1] = '{12'h001, 8'd1,  1'b1};
        vecs[2] = '{12'h5A5, 8'd6,  1'b0};
        vecs[3] = '{12'h800, 8'd1,  1'b1};
        vecs[4] = '{12'h7FF, 8'd11, 1'b1};
        vecs[5] = '{12'h0F0, 8'd4,  1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);

        check("rst_valid", ov_w, 0);
        check("rst_sum", sum_w, 0);
        check("rst_par", par_w, 0);
        check("rst_ovf", of_w, 0);
        check("rst_in_ready", rdy_w, 0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", rdy_w, 1);
        @(negedge clk);

        drive(12'hFFF, 1'b1);
        check("lat_early_valid", ov_w, 0);
        expect_result("fff", 8'd12, 8'd12, 1'b0, 1'b0, 1'b0, w);
        check("latency", w, 1);

        for (int unsigned i = 0; i < 6; i++) begin
            drive(vecs[i].data, 1'b1);
            expect_result($sformatf("vec%0d", i), vecs[i].sum, vecs[i].sum, vecs[i].par, 1'b0, 1'b0, w);
        end

        drive(12'h001, 1'b0);
        drive(12'h003, 1'b0);
        drive(12'h007, 1'b1);
        expect_result("frame3", 8'd6, 8'd6, 1'b0, 1'b0, 1'b0, w);

        for (int unsigned i = 0; i < 21; i++) drive(12'hFFF, 1'b0);
        drive(12'hFFF, 1'b1);
        expect_result("ovf22", 8'd8, 8'd255, 1'b0, 1'b1, 1'b1, w);

        drive(12'hFFF, 1'b1);
        expect_result("after_ovf", 8'd12, 8'd12, 1'b0, 1'b0, 1'b0, w);

        out_ready = 1'b0;
        drive(12'h00F, 1'b1);
        drive(12'h0FF, 1'b1);
        for (int unsigned i = 0; i < 5; i++) begin
            check("bp_in_ready", rdy_w, 0);
            check("bp_valid", ov_w, 1);
            check("bp_sum_w", sum_w, 4);
            check("bp_sum_s", sum_s, 4);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_second_valid", ov_w, 1);
        check("bp_second_sum", sum_w, 8);
        @(negedge clk);
        check("bp_drained", ov_w, 0);

        drive(12'hFFF, 1'b0);
        drive(12'hFFF, 1'b0);
        rst = 1'b1;
        #1;
        check("midrst_in_ready", rdy_w, 0);
        @(negedge clk);
        rst = 1'b0;
        check("midrst_no_result", ov_w, 0);
        drive(12'h00F, 1'b1);
        expect_result("midrst", 8'd4, 8'd4, 1'b0, 1'b0, 1'b0, w);
        check("midrst_latency", w, 1);

        for (int k = 0; k < 12; k++) begin
            if (k >= 2) begin
                check($sformatf("stream%0d_valid", k - 2), ov_w, 1);
                check($sformatf("stream%0d_sum", k - 2), sum_w, k - 2);
                check($sformatf("stream%0d_par", k - 2), par_w, (k - 2) & 1);
            end
            if (k < 10) begin
                v        = 12'((1 << k) - 1);
                in_valid = 1'b1;
                in_data  = v;
                in_last  = 1'b1;
            end else begin
                in_valid = 1'b0;
                in_last  = 1'b0;
            end
            @(negedge clk);
        end
        check("stream_end_valid", ov_w, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
